keypad_emulator: RTL and testbench

- Synthesizable 4x4 matrix-keypad model: the responder end of the column-scan / row-sense interface used by the keypad driver.
- Accepts a key code through a valid/ready handshake. Replays a realistic press: contact bounce, stable hold, release bounce, then an inter-key gap.
- While the contact is closed, it pulls the matching row low whenever the scanner drives that key's column low.
- Used for board self-test and bench stimulus in place of the physical keypad, wired to the scanner's col/fila pins.

---
 rtl/keypad_pkg.sv | 73 +++++++
 rtl/keypad_emulator_if.sv | 34 +++
 rtl/keypad_bounce_gen.sv | 82 ++++++++
 rtl/keypad_emulator.sv | 151 +++++++++++++++
 tb/tb_keypad_emulator.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/keypad_pkg.sv
// ---------------------------------------------------------------------------
// keypad_pkg
// Definitions shared by the keypad emulator and the keypad driver's decoder:
//   - key-code constants for the 4x4 matrix
//   - the row/column lookup table for a key code
//   - the emulator FSM state encoding
//   - a small constant helper for sizing counters
// ---------------------------------------------------------------------------
package keypad_pkg;

   localparam logic [3:0] KEY_0    = 4'd0;
   localparam logic [3:0] KEY_1    = 4'd1;
   localparam logic [3:0] KEY_2    = 4'd2;
   localparam logic [3:0] KEY_3    = 4'd3;
   localparam logic [3:0] KEY_4    = 4'd4;
   localparam logic [3:0] KEY_5    = 4'd5;
   localparam logic [3:0] KEY_6    = 4'd6;
   localparam logic [3:0] KEY_7    = 4'd7;
   localparam logic [3:0] KEY_8    = 4'd8;
   localparam logic [3:0] KEY_9    = 4'd9;
   localparam logic [3:0] KEY_A    = 4'd10;
   localparam logic [3:0] KEY_B    = 4'd11;
   localparam logic [3:0] KEY_C    = 4'd12;
   localparam logic [3:0] KEY_D    = 4'd13;
   localparam logic [3:0] KEY_STAR = 4'd14;
   localparam logic [3:0] KEY_HASH = 4'd15;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_B_PRESS = 3'd1,
      ST_HOLD    = 3'd2,
      ST_B_REL   = 3'd3,
      ST_GAP     = 3'd4
   } state_t;

   typedef struct packed {
      logic [1:0] row;
      logic [1:0] col;
   } key_pos_t;

   // Physical layout:
   //   row0: 1 2 3 A
   //   row1: 4 5 6 B
   //   row2: 7 8 9 C
   //   row3: * 0 # D
   function automatic key_pos_t key_lookup(input logic [3:0] code);
      key_pos_t p;
      case (code)
         KEY_1:    p = '{row: 2'd0, col: 2'd0};
         KEY_2:    p = '{row: 2'd0, col: 2'd1};
         KEY_3:    p = '{row: 2'd0, col: 2'd2};
         KEY_A:    p = '{row: 2'd0, col: 2'd3};
         KEY_4:    p = '{row: 2'd1, col: 2'd0};
         KEY_5:    p = '{row: 2'd1, col: 2'd1};
         KEY_6:    p = '{row: 2'd1, col: 2'd2};
         KEY_B:    p = '{row: 2'd1, col: 2'd3};
         KEY_7:    p = '{row: 2'd2, col: 2'd0};
         KEY_8:    p = '{row: 2'd2, col: 2'd1};
         KEY_9:    p = '{row: 2'd2, col: 2'd2};
         KEY_C:    p = '{row: 2'd2, col: 2'd3};
         KEY_STAR: p = '{row: 2'd3, col: 2'd0};
         KEY_0:    p = '{row: 2'd3, col: 2'd1};
         KEY_HASH: p = '{row: 2'd3, col: 2'd2};
         default:  p = '{row: 2'd3, col: 2'd3};   // KEY_D
      endcase
      return p;
   endfunction

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/keypad_emulator_if.sv
// ---------------------------------------------------------------------------
// keypad_emulator_if
// Bundles the key-request handshake and the matrix scan pins of the keypad
// emulator.
//   key_code : key to press (see keypad_pkg layout)
//   req      : request valid
//   ready    : emulator idle, request accepted on req & ready
//   busy     : emulator replaying a key
//   done     : one-cycle pulse at the end of the inter-key gap
//   col      : column scan from the keypad driver, active-low
//   fila     : row sense back to the keypad driver, active-low
//   contact  : debug view of the emulated switch (1 = closed)
// master = requester / scanner side, slave = emulator side.
// ---------------------------------------------------------------------------
interface keypad_emulator_if;
   logic [3:0] key_code;
   logic       req;
   logic       ready;
   logic       busy;
   logic       done;
   logic [3:0] col;
   logic [3:0] fila;
   logic       contact;

   modport master (
      output key_code, req, col,
      input  ready, busy, done, fila, contact
   );

   modport slave (
      input  key_code, req, col,
      output ready, busy, done, fila, contact
   );
endinterface

// File: rtl/keypad_bounce_gen.sv
// ---------------------------------------------------------------------------
// keypad_bounce_gen
// Phase timer and contact-level generator for one press/release phase.
// A load pulse starts a phase of len_i cycles at level start_lvl_i; when
// bounce_i was set at load the level inverts every BOUNCE_PER cycles,
// otherwise it is held. last_o marks the final cycle of the phase.
//   clk, reset   : clock, synchronous active-high reset
//   load_i       : start a new phase (takes effect next cycle)
//   bounce_i     : phase toggles the contact
//   start_lvl_i  : contact level in the first cycle of the phase
//   len_i        : phase length in cycles (0 behaves as 1)
//   contact_o    : registered contact level
//   last_o       : current cycle is the last one of the phase
// ---------------------------------------------------------------------------
module keypad_bounce_gen #(
   parameter int CNT_W      = 9,
   parameter int PER_W      = 3,
   parameter int BOUNCE_PER = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load_i,
   input  logic             bounce_i,
   input  logic             start_lvl_i,
   input  logic [CNT_W-1:0] len_i,
   output logic             contact_o,
   output logic             last_o
);

   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
   localparam logic [PER_W-1:0] TOG_ONE    = PER_W'(1);
   localparam logic [PER_W-1:0] TOG_RELOAD = PER_W'(BOUNCE_PER - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [PER_W-1:0] tog_q, tog_d;
   logic             lvl_q, lvl_d;
   logic             bnc_q, bnc_d;

   always_comb begin
      cnt_d = cnt_q;
      tog_d = tog_q;
      lvl_d = lvl_q;
      bnc_d = bnc_q;
      if (load_i) begin
         // Counter holds "cycles remaining after this one"
         cnt_d = (len_i == '0) ? '0 : (len_i - CNT_ONE);
         tog_d = TOG_RELOAD;
         lvl_d = start_lvl_i;
         bnc_d = bounce_i;
      end else begin
         if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_ONE;
         end
         if (bnc_q) begin
            if (tog_q == '0) begin
               tog_d = TOG_RELOAD;
               lvl_d = ~lvl_q;
            end else begin
               tog_d = tog_q - TOG_ONE;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
         tog_q <= '0;
         lvl_q <= 1'b0;
         bnc_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         tog_q <= tog_d;
         lvl_q <= lvl_d;
         bnc_q <= bnc_d;
      end
   end

   assign contact_o = lvl_q;
   assign last_o    = (cnt_q == '0);

endmodule

// File: rtl/keypad_emulator.sv
// ---------------------------------------------------------------------------
// keypad_emulator
// Responder end of a 4x4 column-scan / row-sense keypad. A key code taken
// over the req/ready handshake is replayed as press bounce, stable hold,
// release bounce and an inter-key gap. While the emulated contact is closed
// the key's row is pulled low whenever its column is scanned low.
//   clk, reset : clock, synchronous active-high reset
//   kp         : keypad_emulator_if slave (key_code/req/ready/busy/done,
//                col/fila scan pins, contact debug)
// ---------------------------------------------------------------------------
module keypad_emulator
   import keypad_pkg::*;
#(
   parameter int BOUNCE_CYC = 16,
   parameter int BOUNCE_PER = 4,
   parameter int HOLD_CYC   = 256,
   parameter int GAP_CYC    = 128
) (
   input  logic          clk,
   input  logic          reset,
   keypad_emulator_if.slave kp
);

   localparam int MAX_P = max_int(max_int(BOUNCE_CYC, HOLD_CYC),
                                  max_int(GAP_CYC, BOUNCE_PER));
   localparam int CNT_W = $clog2(MAX_P + 1);
   localparam int PER_W = $clog2(BOUNCE_PER + 1);

   localparam logic [CNT_W-1:0] LEN_BNC  = CNT_W'(BOUNCE_CYC);
   localparam logic [CNT_W-1:0] LEN_HOLD = CNT_W'(HOLD_CYC);
   localparam logic [CNT_W-1:0] LEN_GAP  = CNT_W'(GAP_CYC);

   state_t     state_q, state_d;
   logic [1:0] row_q, row_d;
   logic [1:0] col_q, col_d;

   key_pos_t         pos;
   logic             gen_load;
   logic             gen_bounce;
   logic             gen_lvl;
   logic [CNT_W-1:0] gen_len;
   logic             gen_contact;
   logic             gen_last;

   // Every state transition reloads the phase generator with the length
   // and starting contact level of the phase being entered.
   always_comb begin
      state_d    = state_q;
      row_d      = row_q;
      col_d      = col_q;
      gen_load   = 1'b0;
      gen_bounce = 1'b0;
      gen_lvl    = 1'b0;
      gen_len    = '0;
      pos        = key_lookup(kp.key_code);
      case (state_q)
         ST_IDLE: begin
            if (kp.req) begin
               row_d    = pos.row;
               col_d    = pos.col;
               gen_load = 1'b1;
               gen_lvl  = 1'b1;
               if (BOUNCE_CYC == 0) begin
                  state_d = ST_HOLD;
                  gen_len = LEN_HOLD;
               end else begin
                  state_d    = ST_B_PRESS;
                  gen_len    = LEN_BNC;
                  gen_bounce = 1'b1;
               end
            end
         end
         ST_B_PRESS: begin
            if (gen_last) begin
               state_d  = ST_HOLD;
               gen_load = 1'b1;
               gen_lvl  = 1'b1;
               gen_len  = LEN_HOLD;
            end
         end
         ST_HOLD: begin
            if (gen_last) begin
               gen_load = 1'b1;
               gen_lvl  = 1'b0;
               if (BOUNCE_CYC == 0) begin
                  state_d = ST_GAP;
                  gen_len = LEN_GAP;
               end else begin
                  state_d    = ST_B_REL;
                  gen_len    = LEN_BNC;
                  gen_bounce = 1'b1;
               end
            end
         end
         ST_B_REL: begin
            if (gen_last) begin
               state_d  = ST_GAP;
               gen_load = 1'b1;
               gen_lvl  = 1'b0;
               gen_len  = LEN_GAP;
            end
         end
         ST_GAP: begin
            if (gen_last) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         row_q   <= 2'd0;
         col_q   <= 2'd0;
      end else begin
         state_q <= state_d;
         row_q   <= row_d;
         col_q   <= col_d;
      end
   end

   keypad_bounce_gen #(
      .CNT_W      (CNT_W),
      .PER_W      (PER_W),
      .BOUNCE_PER (BOUNCE_PER)
   ) u_bounce (
      .clk         (clk),
      .reset       (reset),
      .load_i      (gen_load),
      .bounce_i    (gen_bounce),
      .start_lvl_i (gen_lvl),
      .len_i       (gen_len),
      .contact_o   (gen_contact),
      .last_o      (gen_last)
   );

   assign kp.ready   = (state_q == ST_IDLE);
   assign kp.busy    = (state_q != ST_IDLE);
   assign kp.done    = (state_q == ST_GAP) && gen_last;
   assign kp.contact = gen_contact;

   // Zero-latency row response: only the latched column is honoured, so
   // several columns scanned low at once still pull at most one row.
   assign kp.fila = (gen_contact && !kp.col[col_q]) ? ~(4'b0001 << row_q)
                                                    : 4'b1111;

endmodule

// File: tb/tb_keypad_emulator.sv
module tb_keypad_emulator;
   import keypad_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_a, rst_b, rst_c;

   keypad_emulator_if ifa ();
   keypad_emulator_if ifb ();
   keypad_emulator_if ifc ();

   // A: no bounce, short hold/gap. B: defaults. C: fast bounce, zero gap.
   keypad_emulator #(.BOUNCE_CYC(0), .BOUNCE_PER(4), .HOLD_CYC(8), .GAP_CYC(4))
      dut_a (.clk(clk), .reset(rst_a), .kp(ifa.slave));
   keypad_emulator dut_b (.clk(clk), .reset(rst_b), .kp(ifb.slave));
   keypad_emulator #(.BOUNCE_CYC(4), .BOUNCE_PER(1), .HOLD_CYC(3), .GAP_CYC(0))
      dut_c (.clk(clk), .reset(rst_c), .kp(ifc.slave));

   localparam int W_FILA = 0, W_CONT = 1, W_RDY = 2, W_BUSY = 3, W_DONE = 4;

   typedef struct {
      int         cyc;
      int         dut;
      int         what;
      logic [3:0] val;
   } exp_t;

   exp_t exp_q[$];
   int   done_qa[$];
   int   done_qb[$];
   int   done_qc[$];

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(input string nm, input int act, input int req);
      n_checks++;
      if (act == req) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, req, cyc);
   endfunction

   function automatic logic [3:0] pick(input logic [3:0] f, input logic c, input logic r,
                                       input logic b, input logic d, input int what);
      case (what)
         W_FILA:  return f;
         W_CONT:  return {3'b000, c};
         W_RDY:   return {3'b000, r};
         W_BUSY:  return {3'b000, b};
         default: return {3'b000, d};
      endcase
   endfunction

   function automatic logic [3:0] get_out(input int d, input int what);
      case (d)
         0:       return pick(ifa.fila, ifa.contact, ifa.ready, ifa.busy, ifa.done, what);
         1:       return pick(ifb.fila, ifb.contact, ifb.ready, ifb.busy, ifb.done, what);
         default: return pick(ifc.fila, ifc.contact, ifc.ready, ifc.busy, ifc.done, what);
      endcase
   endfunction

   // Monitor: compare queued expectations for this cycle, and pop an expected
   // done cycle whenever a DUT presents a done pulse.
   exp_t  mon_e;
   string mon_nm;
   always @(negedge clk) begin
      while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
         mon_e  = exp_q.pop_front();
         mon_nm = $sformatf("dut%0d_sig%0d_c%0d", mon_e.dut, mon_e.what, mon_e.cyc);
         chk(mon_nm, int'(get_out(mon_e.dut, mon_e.what)), int'(mon_e.val));
      end
      if (ifa.done) begin
         if (done_qa.size() == 0) chk("unexpected_done_a", 1, 0);
         else chk("done_cycle_a", cyc, done_qa.pop_front());
      end
      if (ifb.done) begin
         if (done_qb.size() == 0) chk("unexpected_done_b", 1, 0);
         else chk("done_cycle_b", cyc, done_qb.pop_front());
      end
      if (ifc.done) begin
         if (done_qc.size() == 0) chk("unexpected_done_c", 1, 0);
         else chk("done_cycle_c", cyc, done_qc.pop_front());
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_now(input int d, input int what, input logic [3:0] v);
      exp_t e;
      e = '{cyc: cyc, dut: d, what: what, val: v};
      exp_q.push_back(e);
   endtask

   task automatic set_req(input int d, input logic r, input logic [3:0] code);
      case (d)
         0:       begin ifa.req = r; ifa.key_code = code; end
         1:       begin ifb.req = r; ifb.key_code = code; end
         default: begin ifc.req = r; ifc.key_code = code; end
      endcase
   endtask

   task automatic set_col(input int d, input logic [3:0] c);
      case (d)
         0:       ifa.col = c;
         1:       ifb.col = c;
         default: ifc.col = c;
      endcase
   endtask

   // Raise req, wait for ready (bounded), return the acceptance cycle N.
   // Returns positioned in cycle N+1. lat > 0 queues the expected done cycle.
   task automatic accept(input int d, input logic [3:0] code, input bit keep,
                         input int lat, output int n);
      set_req(d, 1'b1, code);
      n = -1;
      for (int t = 0; t < 1000; t++) begin
         if (get_out(d, W_RDY) == 4'd1) begin
            n = cyc;
            break;
         end
         tick();
      end
      if (n < 0) chk("accept_timeout", 0, 1);
      if (lat > 0) begin
         case (d)
            0:       done_qa.push_back(n + lat);
            1:       done_qb.push_back(n + lat);
            default: done_qc.push_back(n + lat);
         endcase
      end
      tick();
      if (!keep) set_req(d, 1'b0, code);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      int         n, n1, n2;
      logic       c;
      logic [3:0] cv;

      rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
      for (int d = 0; d < 3; d++) begin
         set_req(d, 1'b0, 4'd0);
         set_col(d, 4'b1111);
      end
      repeat (3) tick();
      // Reset state
      for (int d = 0; d < 3; d++) begin
         expect_now(d, W_RDY, 4'd1);
         expect_now(d, W_BUSY, 4'd0);
         expect_now(d, W_DONE, 4'd0);
         expect_now(d, W_CONT, 4'd0);
         expect_now(d, W_FILA, 4'b1111);
      end
      rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;

      // Idle scan: no key pressed, rows stay high
      for (int i = 0; i < 8; i++) begin
         tick();
         cv = ~(4'b0001 << (i % 4));
         set_col(0, cv);
         set_col(1, cv);
         expect_now(0, W_FILA, 4'b1111);
         expect_now(1, W_FILA, 4'b1111);
         expect_now(0, W_RDY, 4'd1);
         expect_now(0, W_BUSY, 4'd0);
      end

      // A: key 5 (row1, col1), hold 8, gap 4, done 12 cycles after accept
      set_col(0, 4'b1101);
      accept(0, KEY_5, 1'b0, 12, n);
      for (int t = 1; t <= 13; t++) begin
         set_col(0, (t % 2 == 1) ? 4'b1101 : 4'b1110);
         expect_now(0, W_FILA, (t <= 8 && t % 2 == 1) ? 4'b1101 : 4'b1111);
         expect_now(0, W_CONT, (t <= 8) ? 4'd1 : 4'd0);
         expect_now(0, W_RDY, (t == 13) ? 4'd1 : 4'd0);
         expect_now(0, W_BUSY, (t == 13) ? 4'd0 : 4'd1);
         if (t < 13) tick();
      end

      // B: defaults, key 0 (row3, col1), col held at 1101
      set_col(1, 4'b1101);
      accept(1, KEY_0, 1'b0, 416, n);
      for (int t = 1; t <= 417; t++) begin
         if (t <= 16)       c = (((t - 1) / 4) % 2) == 0;
         else if (t <= 272) c = 1'b1;
         else if (t <= 288) c = (((t - 273) / 4) % 2) == 1;
         else               c = 1'b0;
         expect_now(1, W_CONT, {3'b000, c});
         expect_now(1, W_FILA, {~c, 3'b111});
         expect_now(1, W_RDY, (t == 417) ? 4'd1 : 4'd0);
         if (t < 417) tick();
      end

      // A: back-to-back, req held high, '#' (row3,col2) then 'A' (row0,col3)
      set_col(0, 4'b1011);
      accept(0, KEY_HASH, 1'b1, 12, n1);
      set_req(0, 1'b1, KEY_A);
      for (int t = 1; t <= 12; t++) begin
         expect_now(0, W_FILA, (t <= 8) ? 4'b0111 : 4'b1111);
         expect_now(0, W_RDY, 4'd0);
         tick();
      end
      accept(0, KEY_A, 1'b0, 12, n2);
      chk("b2b_accept_offset", n2 - n1, 13);
      for (int t = 1; t <= 13; t++) begin
         set_col(0, (t >= 5 && t <= 8) ? 4'b0111 : 4'b1011);
         expect_now(0, W_FILA, (t >= 5 && t <= 8) ? 4'b1110 : 4'b1111);
         expect_now(0, W_RDY, (t == 13) ? 4'd1 : 4'd0);
         if (t < 13) tick();
      end

      // A: reset in the middle of HOLD aborts the key with no done pulse
      set_col(0, 4'b1101);
      accept(0, KEY_5, 1'b0, 0, n);
      for (int t = 1; t <= 4; t++) begin
         expect_now(0, W_FILA, 4'b1101);
         if (t < 4) tick();
      end
      rst_a = 1'b1;
      tick();
      expect_now(0, W_FILA, 4'b1111);
      expect_now(0, W_RDY, 4'd1);
      expect_now(0, W_BUSY, 4'd0);
      expect_now(0, W_CONT, 4'd0);
      expect_now(0, W_DONE, 4'd0);
      rst_a = 1'b0;
      for (int t = 0; t < 15; t++) begin
         tick();
         expect_now(0, W_FILA, 4'b1111);
         expect_now(0, W_DONE, 4'd0);
      end

      // C: bounce 4 @ period 1, hold 3, gap 0; key 1 (row0, col0)
      set_col(2, 4'b1110);
      accept(2, KEY_1, 1'b0, 12, n);
      for (int t = 1; t <= 13; t++) begin
         if (t <= 4)       c = (t % 2 == 1);
         else if (t <= 7)  c = 1'b1;
         else if (t <= 11) c = (t % 2 == 1);
         else              c = 1'b0;
         expect_now(2, W_CONT, {3'b000, c});
         expect_now(2, W_FILA, c ? 4'b1110 : 4'b1111);
         expect_now(2, W_DONE, (t == 12) ? 4'd1 : 4'd0);
         expect_now(2, W_RDY, (t == 13) ? 4'd1 : 4'd0);
         if (t < 13) tick();
      end

      repeat (5) tick();
      chk("pending_expectations", exp_q.size(), 0);
      chk("missing_done_a", done_qa.size(), 0);
      chk("missing_done_b", done_qb.size(), 0);
      chk("missing_done_c", done_qc.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
